// File: rtl/async_queue_sink_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : async_queue_sink_ctrl_if
// Description : Signal bundle between the sink-side controller of an
//               asynchronous queue, the shared source memory, the peer's
//               synchronizers and the dequeue consumer.
//               slave  : view taken by async_queue_sink_ctrl
//               master : view taken by the environment (peer, memory, consumer)
//   io_source_valid  peer-alive flag, already synchronized
//   io_widx          Gray write index, already synchronized
//   io_mem_raddr     entry select into the source memory
//   io_mem_rdata     entry contents at io_mem_raddr (same cycle)
//   io_ridx          registered Gray read index back to the peer
//   io_sink_valid    registered sink-alive flag
//   io_deq_valid/io_deq_ready/io_deq_bits  dequeue handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface async_queue_sink_ctrl_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 32
);
    logic                  io_source_valid;
    logic [DEPTH_LOG2:0]   io_widx;
    logic [DEPTH_LOG2-1:0] io_mem_raddr;
    logic [DATA_W-1:0]     io_mem_rdata;
    logic [DEPTH_LOG2:0]   io_ridx;
    logic                  io_sink_valid;
    logic                  io_deq_valid;
    logic                  io_deq_ready;
    logic [DATA_W-1:0]     io_deq_bits;

    modport slave (
        input  io_source_valid,
        input  io_widx,
        input  io_mem_rdata,
        input  io_deq_ready,
        output io_mem_raddr,
        output io_ridx,
        output io_sink_valid,
        output io_deq_valid,
        output io_deq_bits
    );

    modport master (
        output io_source_valid,
        output io_widx,
        output io_mem_rdata,
        output io_deq_ready,
        input  io_mem_raddr,
        input  io_ridx,
        input  io_sink_valid,
        input  io_deq_valid,
        input  io_deq_bits
    );
endinterface
`default_nettype wire

// File: rtl/async_queue_sink_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_queue_sink_ctrl
// Description : Read side of an asynchronous queue. Tracks a binary read
//               counter, publishes its Gray form to the peer, pulls entries
//               out of the source memory into a single output register and
//               presents them on a valid/ready dequeue port. Losing the peer
//               (io_source_valid low) flushes the read side back to zero.
// Ports       : clock   - single clock, all state on rising edge
//               reset   - synchronous, active-high
//               q       - async_queue_sink_ctrl_if.slave bundle
// Revision    : 1.0 - initial release
// ============================================================================
module async_queue_sink_ctrl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 32
) (
    input  wire logic               clock,
    input  wire logic               reset,
    async_queue_sink_ctrl_if.slave  q
);
    localparam int              c_IDX_W = DEPTH_LOG2 + 1;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_rbin;
    logic [c_IDX_W-1:0]  r_ridx;
    logic                r_sink_valid;
    logic                r_deq_valid;
    logic [DATA_W-1:0]   r_deq_bits;

    state_t              w_state_next;
    logic [c_IDX_W-1:0]  w_rbin_next;
    logic [c_IDX_W-1:0]  w_ridx_next;
    logic                w_sink_valid_next;
    logic                w_deq_valid_next;
    logic [DATA_W-1:0]   w_deq_bits_next;
    logic                w_avail;
    logic                w_fire_out;
    logic                w_fill;

    // Entry available only while linked to a live peer and the indices differ.
    assign w_avail    = (r_state == ST_RUN) && q.io_source_valid && (r_ridx != q.io_widx);
    assign w_fire_out = r_deq_valid && q.io_deq_ready;
    // Refill when the output register is empty or is being emptied this cycle.
    assign w_fill     = w_avail && (!r_deq_valid || w_fire_out);

    always_comb begin
        w_state_next     = r_state;
        w_rbin_next      = r_rbin;
        w_deq_valid_next = r_deq_valid;
        w_deq_bits_next  = r_deq_bits;

        case (r_state)
            ST_IDLE: if (q.io_source_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (!q.io_source_valid) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        // Idle holds everything at zero; dropping out of RUN flushes the
        // read side in the same step, whatever the consumer is doing.
        if ((r_state == ST_IDLE) || !q.io_source_valid) begin
            w_rbin_next      = c_IDX_ZERO;
            w_deq_valid_next = 1'b0;
            w_deq_bits_next  = '0;
        end else if (w_fill) begin
            w_rbin_next      = r_rbin + c_IDX_ONE;
            w_deq_valid_next = 1'b1;
            w_deq_bits_next  = q.io_mem_rdata;
        end else if (w_fire_out) begin
            w_deq_valid_next = 1'b0;
        end

        w_ridx_next       = w_rbin_next ^ (w_rbin_next >> 1);
        w_sink_valid_next = (w_state_next == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rbin       <= c_IDX_ZERO;
            r_ridx       <= c_IDX_ZERO;
            r_sink_valid <= 1'b0;
            r_deq_valid  <= 1'b0;
            r_deq_bits   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rbin       <= w_rbin_next;
            r_ridx       <= w_ridx_next;
            r_sink_valid <= w_sink_valid_next;
            r_deq_valid  <= w_deq_valid_next;
            r_deq_bits   <= w_deq_bits_next;
        end
    end

    assign q.io_mem_raddr  = r_rbin[DEPTH_LOG2-1:0];
    assign q.io_ridx       = r_ridx;
    assign q.io_sink_valid = r_sink_valid;
    assign q.io_deq_valid  = r_deq_valid;
    assign q.io_deq_bits   = r_deq_bits;
endmodule
`default_nettype wire

// File: tb/tb_async_queue_sink_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_queue_sink_ctrl
// Description : Self-checking bench for async_queue_sink_ctrl. The bench owns
//               the source memory and write pointer; every enqueued word is
//               pushed to an expected queue and a negedge monitor pops and
//               compares on each dequeue handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_queue_sink_ctrl;
    localparam int c_DL = 3;
    localparam int c_DW = 32;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [c_DW-1:0] mem [0:7];
    logic [c_DW-1:0] exp_q [$];
    int   wptr;      // entries written in the current session
    int   n_pop;     // entries taken by the consumer in the current session
    bit   mon_en;

    async_queue_sink_ctrl_if #(.DEPTH_LOG2(c_DL), .DATA_W(c_DW)) q();

    async_queue_sink_ctrl #(.DEPTH_LOG2(c_DL), .DATA_W(c_DW)) dut (
        .clock (clock),
        .reset (reset),
        .q     (q)
    );

    assign q.io_mem_rdata = mem[q.io_mem_raddr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write one word into the next memory slot and publish the new index.
    task automatic enq(input logic [c_DW-1:0] d);
        mem[wptr % 8] = d;
        wptr++;
        q.io_widx = gray4(wptr);
        exp_q.push_back(d);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic new_session();
        mon_en = 0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        q.io_source_valid = 1'b1;
        q.io_widx = '0;
        exp_q.delete();
        wptr  = 0;
        n_pop = 0;
        tick();
        mon_en = 1;
    endtask

    // Monitor: order/data scoreboard, index coherence and hold stability.
    initial begin : monitor
        bit              hold_prev;
        logic [c_DW-1:0] prev_bits;
        logic [c_DW-1:0] e;
        int              fills;
        hold_prev = 0;
        prev_bits = '0;
        forever begin
            @(negedge clock);
            if (!mon_en || reset) begin
                hold_prev = 0;
            end else begin
                fills = n_pop + (q.io_deq_valid ? 1 : 0);
                chk("ridx_vs_consumed", 64'(q.io_ridx), 64'(gray4(fills % 16)));
                chk("raddr_vs_consumed", 64'(q.io_mem_raddr), 64'(fills % 8));
                if (hold_prev) begin
                    chk("hold_valid", 64'(q.io_deq_valid), 64'd1);
                    chk("hold_bits", 64'(q.io_deq_bits), 64'(prev_bits));
                end
                if (q.io_deq_valid && q.io_deq_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL deq_unexpected: got %0h expected none", q.io_deq_bits);
                    end else begin
                        e = exp_q.pop_front();
                        chk("deq_data", 64'(q.io_deq_bits), 64'(e));
                    end
                    n_pop++;
                end
                hold_prev = q.io_deq_valid && !q.io_deq_ready && q.io_source_valid;
                prev_bits = q.io_deq_bits;
            end
        end
    end

    initial begin : stim
        logic [3:0] ridx_steps [0:7];
        int         k;
        int         guard;
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 0;
        wptr    = 0;
        n_pop   = 0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset = 1'b1;
        q.io_source_valid = 1'b0;
        q.io_widx         = '0;
        q.io_deq_ready    = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ridx", 64'(q.io_ridx), 64'd0);
        chk("rst_sink_valid", 64'(q.io_sink_valid), 64'd0);
        chk("rst_deq_valid", 64'(q.io_deq_valid), 64'd0);
        chk("rst_deq_bits", 64'(q.io_deq_bits), 64'd0);
        chk("rst_raddr", 64'(q.io_mem_raddr), 64'd0);

        // No RUN without a live peer
        reset = 1'b0;
        tick();
        chk("idle_no_peer", 64'(q.io_sink_valid), 64'd0);

        // Peer comes alive with an empty queue
        q.io_source_valid = 1'b1;
        tick();
        chk("run_sink_valid", 64'(q.io_sink_valid), 64'd1);
        chk("run_empty_valid", 64'(q.io_deq_valid), 64'd0);
        n_pop = 0;
        wptr  = 0;
        mon_en = 1;

        // Single entry, consumer stalled, one-cycle latency then hold
        enq(32'hA5A5_0001);
        tick();
        chk("one_valid", 64'(q.io_deq_valid), 64'd1);
        chk("one_bits", 64'(q.io_deq_bits), 64'hA5A5_0001);
        chk("one_ridx", 64'(q.io_ridx), 64'b0001);
        repeat (3) tick();
        chk("one_held", 64'(q.io_deq_valid), 64'd1);
        q.io_deq_ready = 1'b1;
        tick();
        chk("one_taken", 64'(q.io_deq_valid), 64'd0);

        // Eight entries at once, consumer always ready: back-to-back dequeue
        new_session();
        ridx_steps = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        q.io_deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem[i] = $urandom;
            exp_q.push_back(mem[i]);
        end
        wptr = 8;
        q.io_widx = gray4(8);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("burst_valid", 64'(q.io_deq_valid), 64'd1);
            chk("burst_ridx", 64'(q.io_ridx), 64'(ridx_steps[i]));
        end
        tick();
        chk("burst_end_valid", 64'(q.io_deq_valid), 64'd0);

        // Randomized traffic: bursty writes, random backpressure, index wraps
        for (int c = 0; c < 400; c++) begin
            q.io_deq_ready = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 3);
            while (k > 0 && exp_q.size() < 8) begin
                enq($urandom);
                k--;
            end
            tick();
        end
        q.io_deq_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || q.io_deq_valid) && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_done", 64'(exp_q.size() == 0 && !q.io_deq_valid), 64'd1);
        chk("drain_wrapped", 64'(wptr > 16), 64'd1);

        // Peer drops while an entry is held: flush
        q.io_deq_ready = 1'b0;
        enq(32'h1234_5678);
        tick();
        chk("pre_flush_valid", 64'(q.io_deq_valid), 64'd1);
        mon_en = 0;
        q.io_source_valid = 1'b0;
        tick();
        chk("flush_valid", 64'(q.io_deq_valid), 64'd0);
        chk("flush_ridx", 64'(q.io_ridx), 64'd0);
        chk("flush_sink_valid", 64'(q.io_sink_valid), 64'd0);
        chk("flush_bits", 64'(q.io_deq_bits), 64'd0);

        // Reset coincides with a fill
        new_session();
        mon_en = 0;
        q.io_deq_ready = 1'b0;
        enq(32'hDEAD_BEEF);
        reset = 1'b1;
        tick();
        chk("rstfill_valid", 64'(q.io_deq_valid), 64'd0);
        chk("rstfill_bits", 64'(q.io_deq_bits), 64'd0);
        chk("rstfill_ridx", 64'(q.io_ridx), 64'd0);
        chk("rstfill_sink", 64'(q.io_sink_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("after_rst_run", 64'(q.io_sink_valid), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/async_queue_sink_ctrl.md
ASYNC_QUEUE_SINK_CTRL -- requirements
Module: async_queue_sink_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 3, log2 of queue entries (depth 8).
REQ-002 The block SHALL have parameter DATA_W, default 32, entry width.
REQ-003 The block SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port io_source_valid, input, 1: peer-alive flag, already synchronized into this domain by the valid synchronizer.
REQ-006 The block SHALL have port io_widx, input, DEPTH_LOG2+1: Gray-coded write index, already synchronized.
REQ-007 The block SHALL have port io_mem_raddr, output, DEPTH_LOG2: entry select into the source memory.
REQ-008 The block SHALL have port io_mem_rdata, input, DATA_W: entry contents at io_mem_raddr, same cycle.
REQ-009 The block SHALL have port io_ridx, output, DEPTH_LOG2+1: registered Gray read index to the peer.
REQ-010 The block SHALL have port io_sink_valid, output, 1: registered sink-alive flag to the peer's valid synchronizer.
REQ-011 The block SHALL have port io_deq_valid, output, 1: registered dequeue valid.
REQ-012 The block SHALL have port io_deq_ready, input, 1: consumer ready.
REQ-013 The block SHALL have port io_deq_bits, output, DATA_W: registered dequeue data.

Function
REQ-014 Internal binary read counter rbin, DEPTH_LOG2+1 bits, SHALL wrap modulo 2^(DEPTH_LOG2+1).
REQ-015 io_ridx SHALL be a register loaded with rbin_next ^ (rbin_next >> 1) whenever rbin updates.
REQ-016 io_mem_raddr SHALL equal rbin[DEPTH_LOG2-1:0], combinational from the rbin register.
REQ-017 FSM states SHALL be IDLE and RUN; io_sink_valid SHALL be 1 exactly in RUN.
REQ-018 IDLE->RUN SHALL occur on a cycle with io_source_valid=1; RUN->IDLE on a cycle with io_source_valid=0.
REQ-019 In IDLE, rbin, io_ridx, io_deq_valid and io_deq_bits SHALL be held at 0.
REQ-020 Entering IDLE from RUN SHALL flush: next cycle rbin=0, io_ridx=0, io_deq_valid=0, regardless of io_deq_ready.
REQ-021 avail SHALL equal (state==RUN) && io_source_valid && (io_ridx != io_widx).
REQ-022 fire_out SHALL equal io_deq_valid && io_deq_ready.
REQ-023 Fill SHALL occur when avail && (!io_deq_valid || fire_out): io_deq_bits<=io_mem_rdata, io_deq_valid<=1, rbin<=rbin+1.
REQ-024 fire_out without fill SHALL set io_deq_valid<=0 and leave io_deq_bits unchanged.
REQ-025 While io_deq_valid=1 and io_deq_ready=0, io_deq_bits and io_deq_valid SHALL be stable.
REQ-026 Simultaneous fire_out and fill SHALL sustain one entry per cycle with no bubble.
REQ-027 Latency: io_widx change to io_deq_valid=1 SHALL be exactly 1 cycle when the output register is empty.
REQ-028 At most one entry SHALL be consumed per cycle; the block never reads when io_ridx==io_widx.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL enter IDLE with rbin=0, io_ridx=0, io_sink_valid=0, io_deq_valid=0, io_deq_bits=0.
REQ-030 Reset SHALL override all other events, including an in-flight fill or dequeue.
REQ-031 The first RUN cycle SHALL be no earlier than the cycle after reset deasserts with io_source_valid=1.

Verification
REQ-032 Reset, then io_source_valid=1, io_widx=0 -> io_sink_valid=1 next cycle; io_deq_valid stays 0.
REQ-033 In RUN, io_widx=0001 (one entry), io_mem_rdata=0xA5A5_0001, io_deq_ready=0 -> next cycle io_deq_valid=1, io_deq_bits=0xA5A5_0001, io_ridx=0001; held until ready.
REQ-034 io_widx=Gray(8) with ready=1 continuously -> 8 consecutive dequeue cycles, io_ridx steps 0001,0011,0010,0110,0111,0101,0100,1100, then io_deq_valid=0.
REQ-035 Wrap: rbin=15 (io_ridx=1000), one entry available, fill -> rbin=0, io_ridx=0000, io_mem_raddr=0.
REQ-036 io_source_valid drops while io_deq_valid=1 and ready=0 -> next cycle IDLE, io_deq_valid=0, io_ridx=0, io_sink_valid=0.
REQ-037 Reset asserted in the same cycle as a fill -> next cycle all outputs 0, state IDLE.
